// File: rtl/lti_sample_sequencer_if.sv
// Sample-side link between the sequencer and lti_system, plus the FWFT output stream.
interface lti_sample_sequencer_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned OW = 16
);
  // LTI filter side
  logic [IW-1:0] lti_sig_in;
  logic          lti_ce_in;
  logic [OW-1:0] lti_sig_out;
  logic          lti_ce_out;
  // Captured-sample stream
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  // Sequencer side: drives ce_in/sig_in and the stream head
  modport master (
    output lti_sig_in, lti_ce_in, out_data, out_valid,
    input  lti_sig_out, lti_ce_out, out_ready
  );

  // Filter/consumer side
  modport slave (
    input  lti_sig_in, lti_ce_in, out_data, out_valid,
    output lti_sig_out, lti_ce_out, out_ready
  );
endinterface

// File: rtl/lti_sample_sequencer.sv
// Periodic sample issuer for lti_system: strobes ce_in every DIV clocks with the
// zero-order-held ADC sample, waits for ce_out, and queues sig_out in a FWFT FIFO.
// Overrun (missed tick / FIFO drop) and response timeout are reported as sticky flags.
module lti_sample_sequencer #(
  parameter int unsigned IW    = 16,
  parameter int unsigned OW    = 16,
  parameter int unsigned DIV   = 100,
  parameter int unsigned TOUT  = 15,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [IW-1:0]                adc_data,
  input  logic                         adc_valid,
  lti_sample_sequencer_if.master       bus,
  output logic                         overrun,
  output logic                         timeout_err,
  input  logic                         clr_err,
  output logic [15:0]                  sample_cnt
);

  localparam int unsigned TICK_W = 16;
  localparam int unsigned WAIT_W = 16;
  localparam int unsigned CW     = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic                tick_c;
  logic [IW-1:0]       hold_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ce_in_q, ce_in_d;
  logic [IW-1:0]       sig_in_q, sig_in_d;
  logic                push_c;
  logic                tout_c;
  logic                miss_c;

  logic [OW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_q, rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                full_c;
  logic                pop_c;
  logic                accept_c;
  logic                drop_c;
  logic [OW-1:0]       out_data_q;
  logic                out_valid_q;
  logic                overrun_q;
  logic                timeout_q;
  logic [15:0]         sample_cnt_q;

  // Sample-period timebase: tick on the last count of each DIV-clock period
  assign tick_c = enable && (tick_cnt_q == TICK_W'(DIV - 1));

  // Tick counter, parked at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (!enable || tick_c) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Zero-order hold of the latest ADC sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (adc_valid) begin
      hold_q <= adc_data;
    end
  end

  // Sequencer state and registered link outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      ce_in_q  <= 1'b0;
      sig_in_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      ce_in_q  <= ce_in_d;
      sig_in_q <= sig_in_d;
    end
  end

  // Next-state: ce_in/sig_in are loaded on the IDLE->ISSUE transition so they
  // are visible exactly during ISSUE. The wait counter holds clocks spent in
  // WAIT; giving up when it equals TOUT-2 raises timeout_err exactly TOUT
  // clocks after ISSUE (TOUT must be >= 2).
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ce_in_d  = 1'b0;
    sig_in_d = sig_in_q;
    push_c   = 1'b0;
    tout_c   = 1'b0;
    miss_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_c) begin
          state_d  = S_ISSUE;
          ce_in_d  = 1'b1;
          sig_in_d = hold_q;
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        miss_c = tick_c;
        wait_d = wait_q + WAIT_W'(1);
        if (bus.lti_ce_out) begin
          push_c  = 1'b1;
          state_d = S_IDLE;
        end else if (wait_q == WAIT_W'(TOUT - 2)) begin
          tout_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a push into a full FIFO survives only if a pop frees a slot
  assign full_c   = (cnt_q == CW'(DEPTH));
  assign pop_c    = out_valid_q && bus.out_ready;
  assign accept_c = push_c && (!full_c || pop_c);
  assign drop_c   = push_c && full_c && !pop_c;
  assign rd_d     = rd_q + AW'(pop_c);
  assign cnt_d    = cnt_q + CW'(accept_c) - CW'(pop_c);

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_q[wr_q] <= bus.lti_sig_out;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept_c) begin
        wr_q <= wr_q + AW'(1);
      end
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Registered FWFT head: bypass the incoming sample when it lands on the new head slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (cnt_d != '0);
      if (cnt_d != '0) begin
        out_data_q <= (accept_c && (rd_d == wr_q)) ? bus.lti_sig_out : mem_q[rd_d];
      end
    end
  end

  // Sticky error flags; a set event beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (miss_c || drop_c) begin
        overrun_q <= 1'b1;
      end else if (clr_err) begin
        overrun_q <= 1'b0;
      end
      if (tout_c) begin
        timeout_q <= 1'b1;
      end else if (clr_err) begin
        timeout_q <= 1'b0;
      end
    end
  end

  // Accepted-sample counter, wraps at 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
    end else if (accept_c) begin
      sample_cnt_q <= sample_cnt_q + 16'd1;
    end
  end

  assign bus.lti_ce_in  = ce_in_q;
  assign bus.lti_sig_in = sig_in_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign overrun        = overrun_q;
  assign timeout_err    = timeout_q;
  assign sample_cnt     = sample_cnt_q;

endmodule
